// File: rtl/spi_slave.sv
// SPI target: oversamples SCLK/SS_N/MOSI in the clk domain, run-time CPOL/CPHA, single-entry tx buffer.
// Define SPI_SLAVE_LSB_FIRST_EN to shift words LSB first in both directions (default MSB first).
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam int OUT_BIT = 0;
`else
  localparam int OUT_BIT = DATA_WIDTH - 1;
`endif

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q;
  logic [2:0]            sclk_q;   // [0],[1] synchroniser, [2] edge-detect delay
  logic [2:0]            ss_q;
  logic [1:0]            mosi_q;
  logic                  cpol_q, cpha_q;
  logic [DATA_WIDTH-1:0] buf_q, tx_sh_q, rx_sh_q, rx_data_q;
  logic                  buf_full_q;
  logic [CW-1:0]         cnt_q;
  logic                  word_done_q, first_pend_q;
  logic                  miso_q, miso_oe_q, rx_valid_q, tx_underrun_q;

  logic                  lead_e, trail_e, sample_e, shift_e, ss_fall, ss_rise, hs, word_start;
  logic [DATA_WIDTH-1:0] load_word, rx_sh_d, tx_sh_d;

  always_comb begin
    lead_e     = cpol_q ? (~sclk_q[1] & sclk_q[2]) : (sclk_q[1] & ~sclk_q[2]);
    trail_e    = cpol_q ? (sclk_q[1] & ~sclk_q[2]) : (~sclk_q[1] & sclk_q[2]);
    sample_e   = cpha_q ? trail_e : lead_e;
    shift_e    = cpha_q ? lead_e : trail_e;
    ss_fall    = ~ss_q[1] & ss_q[2];
    ss_rise    = ss_q[1] & ~ss_q[2];
    hs         = tx_valid & ~buf_full_q;
    load_word  = buf_full_q ? buf_q : '0;
    // A word starts on select, or on the first shift edge after a completed word.
    word_start = ((state_q == IDLE) & ss_fall) |
                 ((state_q == ACTIVE) & ~ss_rise & word_done_q & shift_e);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    rx_sh_d    = {mosi_q[1], rx_sh_q[DATA_WIDTH-1:1]};
    tx_sh_d    = tx_sh_q >> 1;
`else
    rx_sh_d    = {rx_sh_q[DATA_WIDTH-2:0], mosi_q[1]};
    tx_sh_d    = tx_sh_q << 1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sclk_q        <= '0;
      ss_q          <= '0;
      mosi_q        <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      rx_data_q     <= '0;
      cnt_q         <= '0;
      word_done_q   <= 1'b0;
      first_pend_q  <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_q        <= {sclk_q[1:0], sclk};
      ss_q          <= {ss_q[1:0], ss_n};
      mosi_q        <= {mosi_q[0], mosi};
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= word_start & ~buf_full_q;

      // Handshake is applied after the word-start drain so a same-cycle fill survives.
      if (word_start) buf_full_q <= 1'b0;
      if (hs) begin
        buf_q      <= tx_data;
        buf_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          miso_q      <= 1'b0;
          miso_oe_q   <= 1'b0;
          cnt_q       <= '0;
          word_done_q <= 1'b0;
          if (ss_fall) begin
            state_q      <= ACTIVE;
            miso_oe_q    <= 1'b1;
            tx_sh_q      <= load_word;
            first_pend_q <= cpha_q;
            if (!cpha_q) miso_q <= load_word[OUT_BIT];
          end else begin
            cpol_q <= i_cpol;
            cpha_q <= i_cpha;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q      <= IDLE;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            cnt_q        <= '0;
            word_done_q  <= 1'b0;
            first_pend_q <= 1'b0;
          end else begin
            if (sample_e) begin
              rx_sh_q <= rx_sh_d;
              if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                rx_data_q   <= rx_sh_d;
                rx_valid_q  <= 1'b1;
                cnt_q       <= '0;
                word_done_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            if (shift_e) begin
              if (word_done_q) begin
                tx_sh_q     <= load_word;
                miso_q      <= load_word[OUT_BIT];
                word_done_q <= 1'b0;
              end else if (first_pend_q) begin
                miso_q       <= tx_sh_q[OUT_BIT];
                first_pend_q <= 1'b0;
              end else begin
                tx_sh_q <= tx_sh_d;
                miso_q  <= tx_sh_d[OUT_BIT];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table, hand-written abort/reset
// sequences, and randomized transfers checked against a word-level reference model.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_cpol = 1'b0, i_cpha = 1'b0;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid;

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_cpol(i_cpol), .i_cpha(i_cpha),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: collects received words and counts underrun strobes.
  logic [7:0] rxq[$];
  int         und_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_underrun) und_cnt++;
  end

  // Feeder: hands queued words to the DUT whenever its buffer is empty.
  logic [7:0] feed_w[256];
  int         feed_wr = 0;
  int         feed_rd = 0;
  initial begin
    tx_data  = '0;
    tx_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (feed_rd < feed_wr && tx_ready && !rst) begin
        tx_data  = feed_w[feed_rd];
        tx_valid = 1'b1;
        feed_rd++;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    end
  end

  logic [7:0] misoq[$];
  logic       oe_mid;
  logic [7:0] last_rx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] line_to_word(input logic [7:0] line);
    logic [7:0] w;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) w[i] = line[7-i];
`else
    w = line;
`endif
    return w;
  endfunction

  function automatic logic line_bit(input logic [7:0] w, input int b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return w[b];
`else
    return w[7-b];
`endif
  endfunction

  task automatic feed(input logic [7:0] w);
    feed_w[feed_wr] = w;
    feed_wr++;
  endtask

  // Master: n words, optional abort after abort_bits bits (0 = none).
  task automatic xfer(input bit cpol, input bit cpha, input int n,
                      input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                      input int abort_bits);
    logic [7:0] mw[3];
    logic [7:0] line;
    int         bits;
    bit         stop;
    mw[0] = w0; mw[1] = w1; mw[2] = w2;
    i_cpol = cpol; i_cpha = cpha; sclk = cpol; mosi = 1'b0;
    repeat (8) @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    bits = 0; stop = 1'b0;
    for (int w = 0; w < n && !stop; w++) begin
      line = '0;
      for (int b = 0; b < 8 && !stop; b++) begin
        if (!cpha) begin
          mosi = line_bit(mw[w], b);
          repeat (HALF) @(negedge clk);
          line = {line[6:0], miso};
          if (w == 0 && b == 0) oe_mid = miso_oe;
          sclk = ~cpol;
          repeat (HALF) @(negedge clk);
          sclk = cpol;
        end else begin
          sclk = ~cpol;
          mosi = line_bit(mw[w], b);
          repeat (HALF) @(negedge clk);
          line = {line[6:0], miso};
          if (w == 0 && b == 0) oe_mid = miso_oe;
          sclk = cpol;
          repeat (HALF) @(negedge clk);
        end
        bits++;
        if (bits == abort_bits) stop = 1'b1;
      end
      if (!stop) misoq.push_back(line_to_word(line));
    end
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Reference model: every word start takes the buffered word or underruns;
  // with CPHA=0 the closing trailing edge of the last word starts one extra word.
  task automatic run_case(input string name, input bit cpol, input bit cpha, input int n,
                          input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                          input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                          input bit preload);
    logic [7:0] mexp[3];
    logic [7:0] texp[3];
    int rb, ub, mb, starts, exp_und;
    mexp[0] = m0; mexp[1] = m1; mexp[2] = m2;
    texp[0] = t0; texp[1] = t1; texp[2] = t2;
    rb = rxq.size(); ub = und_cnt; mb = misoq.size();
    if (preload) begin
      for (int i = 0; i < n; i++) feed(texp[i]);
    end
    xfer(cpol, cpha, n, m0, m1, m2, 0);
    chk({name, "_rx_count"}, rxq.size() - rb, n);
    for (int i = 0; i < n; i++) begin
      if (rb + i < rxq.size()) chk({name, "_rx_word"}, rxq[rb+i], mexp[i]);
      if (mb + i < misoq.size()) chk({name, "_miso_word"}, misoq[mb+i], preload ? texp[i] : 8'h00);
    end
    starts  = n + (cpha ? 0 : 1);
    exp_und = starts - (preload ? n : 0);
    chk({name, "_underruns"}, und_cnt - ub, exp_und);
    chk({name, "_oe_active"}, oe_mid, 1'b1);
    chk({name, "_oe_idle"}, {miso_oe, miso}, 2'b00);
    last_rx = mexp[n-1];
  endtask

  typedef struct {
    string      name;
    bit         cpol;
    bit         cpha;
    logic [7:0] m;
    logic [7:0] t;
    bit         pre;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int rb, ub, mb;
    tbl[0] = '{"mode0",    1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C, 1};
    tbl[1] = '{"mode1",    1'b0, 1'b1, 8'h5A, 8'hC3, 1'b1, 8'h5A, 8'hC3, 0};
    tbl[2] = '{"mode2",    1'b1, 1'b0, 8'hC3, 8'h5A, 1'b1, 8'hC3, 8'h5A, 1};
    tbl[3] = '{"mode3",    1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1, 8'h5A, 8'hC3, 0};
    tbl[4] = '{"underrun", 1'b0, 1'b0, 8'h96, 8'hFF, 1'b0, 8'h96, 8'h00, 2};

    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_miso", miso, 1'b0);
    chk("reset_oe", miso_oe, 1'b0);
    chk("reset_tx_ready", tx_ready, 1'b1);
    chk("reset_rx", {rx_valid, rx_data, tx_underrun}, 10'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    foreach (tbl[k]) begin
      rb = rxq.size(); ub = und_cnt; mb = misoq.size();
      if (tbl[k].pre) begin
        feed(tbl[k].t);
        repeat (6) @(negedge clk);
      end
      xfer(tbl[k].cpol, tbl[k].cpha, 1, tbl[k].m, 8'h00, 8'h00, 0);
      chk({tbl[k].name, "_rx_count"}, rxq.size() - rb, 1);
      if (rxq.size() > rb) chk({tbl[k].name, "_rx"}, rxq[rb], tbl[k].exp_rx);
      if (misoq.size() > mb) chk({tbl[k].name, "_miso"}, misoq[mb], tbl[k].exp_miso);
      chk({tbl[k].name, "_underruns"}, und_cnt - ub, tbl[k].exp_und);
      chk({tbl[k].name, "_oe"}, oe_mid, 1'b1);
      chk({tbl[k].name, "_rx_data_held"}, rx_data, tbl[k].exp_rx);
      last_rx = tbl[k].exp_rx;
    end

    run_case("b2b", 1'b0, 1'b1, 3, 8'h01, 8'h02, 8'h03, 8'hA1, 8'hB2, 8'hC3, 1'b1);

    // Abort after 5 bits: no strobe, rx_data held, next word clean.
    rb = rxq.size(); ub = und_cnt;
    feed(8'h11);
    repeat (6) @(negedge clk);
    xfer(1'b0, 1'b0, 1, 8'h33, 8'h00, 8'h00, 5);
    chk("abort_no_rx", rxq.size() - rb, 0);
    chk("abort_rx_held", rx_data, last_rx);
    chk("abort_underruns", und_cnt - ub, 0);
    chk("abort_oe_idle", miso_oe, 1'b0);
    run_case("abort_next", 1'b0, 1'b0, 1, 8'h7E, 8'h00, 8'h00, 8'h42, 8'h00, 8'h00, 1'b1);

    // Reset in the middle of a word with the tx buffer refilled.
    feed(8'h55);
    i_cpol = 1'b0; i_cpha = 1'b0; sclk = 1'b0;
    repeat (8) @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    feed(8'h66);
    repeat (6) @(negedge clk);
    chk("pre_reset_buffer_full", tx_ready, 1'b0);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    rb = rxq.size(); ub = und_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_miso", miso, 1'b0);
    chk("midrst_oe", miso_oe, 1'b0);
    chk("midrst_tx_ready", tx_ready, 1'b1);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_strobes", {rx_valid, tx_underrun}, 2'b00);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_strobes", (rxq.size() - rb) + (und_cnt - ub), 0);
    run_case("rst_next", 1'b0, 1'b0, 1, 8'h81, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 1'b1);

    for (int it = 0; it < 12; it++) begin
      run_case("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 3)),
               8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
